ps2_rx_frame: RTL and testbench
===============================

Name: ps2_rx_frame

Overview:
- PS/2 link-layer receiver; sits directly upstream of the keyboard scancode decoder.
- Synchronises the raw PS2_CLK and PS2_DAT pins into the 50 MHz domain and filters glitches.
- Deserialises 11-bit device-to-host frames, checks start, odd parity and stop bits, and aborts stalled frames on timeout.
- Delivers each good byte to the scancode decoder as a one-cycle strobe.

Parameters:
- FILTER_LEN, 4: consecutive identical synchronised samples required before the filtered PS/2 clock changes; legal range 2..15.
- TIMEOUT_CYCLES, 100000: idle clock cycles inside a frame before it is aborted (2 ms at 50 MHz).

Ports:
- i_clk  in  1  system clock, CLOCK_50.
- i_rst  in  1  asynchronous, active-high reset.
- i_ps2_clk  in  1  raw PS/2 clock pin, asynchronous.
- i_ps2_dat  in  1  raw PS/2 data pin, asynchronous.
- o_data  out  8  last correctly received byte.
- o_valid  out  1  one-cycle strobe; o_data was updated this cycle.
- o_parity_err  out  1  one-cycle strobe; frame rejected on parity.
- o_frame_err  out  1  one-cycle strobe; frame rejected on bad stop bit or timeout.
- o_busy  out  1  high while a frame is in progress (any state except IDLE).

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-high.
- Reset values:
  - o_data = 8'h00; o_valid, o_parity_err, o_frame_err, o_busy = 0.
  - State = IDLE; all counters 0.
  - Filtered clock and both sync stages = 1 (bus-idle level).
- Synchronisation: i_ps2_clk and i_ps2_dat each pass through a 2-flop synchroniser.
- Filter:
  - Filtered clock fclk takes the synchronised clock value only after it has differed from fclk for FILTER_LEN consecutive cycles.
  - Any agreeing sample clears the filter counter.
  - Data is not filtered.
- Edge strobe:
  - fall = fclk_prev & ~fclk, exactly one cycle per accepted falling edge.
  - Data is sampled from the synchronised data in the fall cycle.
- State machine (advances only on fall, except the timeout):
  - IDLE: sampled 0 → DATA with bitcnt = 0. Sampled 1 (spurious start) → stay IDLE, no error strobe.
  - DATA: shift the sampled bit in LSB-first. After the 8th bit → PARITY.
  - PARITY: capture the parity bit → STOP.
  - STOP:
    - Check passes when the XOR of the 8 data bits and the parity bit is 1 (odd parity).
    - Stop = 1 and parity good → o_data <= shift register, o_valid = 1.
    - Stop = 1 and parity bad → o_parity_err = 1; o_data unchanged.
    - Stop = 0 → o_frame_err = 1 regardless of parity; o_data unchanged.
    - Always return to IDLE.
- Latency: strobes assert in the cycle after the stop-bit fall strobe. From the raw i_ps2_clk falling edge this is exactly FILTER_LEN + 3 cycles, assuming data is stable.
- Timeout:
  - Counter clears on every fall and in IDLE.
  - In non-IDLE states it increments each cycle.
  - On reaching TIMEOUT_CYCLES: o_frame_err pulses for one cycle, state → IDLE, counter clears.
  - A fall in the same cycle as the timeout: the timeout wins and the edge is discarded.
- Strobes are mutually exclusive and never asserted in consecutive cycles for the same frame.
- o_data holds its value between valid strobes.
- Reset mid-frame: immediate return to reset values; the partial frame is discarded with no strobe.

Test Plan:
- Good frame:
  - Stimulus: 0x1C with bits 0,0,0,1,1,1,0,0,0,0,1 (start, LSB-first data, parity=0, stop); PS/2 clock at 12.5 kHz.
  - Response: o_valid exactly one cycle, FILTER_LEN+3 cycles after the 11th falling edge; o_data = 8'h1C; o_busy low afterwards.
- Parity error:
  - Stimulus: 0x1C with parity bit = 1.
  - Response: o_parity_err one pulse; o_valid never asserts; o_data keeps its previous value 8'h1C.
- Bad stop:
  - Stimulus: 0xF0, parity 1, stop bit 0.
  - Response: o_frame_err one pulse; no o_valid.
  - Follow-up: an immediately following good 0xF0 frame gives o_valid with o_data = 8'hF0.
- Timeout:
  - Stimulus: start bit plus 4 data bits, then hold the clock high.
  - Response: o_frame_err exactly TIMEOUT_CYCLES = 100000 cycles after the last fall strobe; o_busy drops the same cycle.
  - Follow-up: the next good 0x1C frame is received correctly.
- Glitch rejection: a 2-cycle (< FILTER_LEN) low pulse on i_ps2_clk while IDLE with data 0 → no state change, o_busy stays 0, no strobes.
- Reset mid-frame:
  - Stimulus: assert i_rst after 6 bits of a frame, release, send good frame 0x5A (parity 1).
  - Response: all outputs are at reset values during reset; the only strobe is o_valid with o_data = 8'h5A.

Source files
------------

// File: rtl/ps2_rx_frame_if.sv
// PS/2 receiver bundle: raw pins toward the receiver and the byte/strobe outputs back out.
// The receiver takes the slave modport; the driving side (pins and decoder) takes master.
interface ps2_rx_frame_if;
    logic       i_ps2_clk;
    logic       i_ps2_dat;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_parity_err;
    logic       o_frame_err;
    logic       o_busy;

    modport master (
        output i_ps2_clk, i_ps2_dat,
        input  o_data, o_valid, o_parity_err, o_frame_err, o_busy
    );

    modport slave (
        input  i_ps2_clk, i_ps2_dat,
        output o_data, o_valid, o_parity_err, o_frame_err, o_busy
    );
endinterface

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: synchronise, glitch-filter the clock, deserialise
// 11-bit frames, check start/odd parity/stop and abort stalled frames on timeout.
module ps2_rx_frame #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic           i_clk,
    input  logic           i_rst,
    ps2_rx_frame_if.slave  bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t        state, state_nxt;
    logic          clk_sync_p0, clk_sync_p1;
    logic          dat_sync_p0, dat_sync_p1;
    logic          fclk, fclk_prev;
    logic [3:0]    fcnt;
    logic          fall;
    logic          sample;
    logic [2:0]    bitcnt;
    logic [TW-1:0] tcnt;
    logic          timeout;
    logic [7:0]    shreg;
    logic          par_bit;
    logic          shift_en, par_en;
    logic          valid_nxt, perr_nxt, ferr_nxt;
    logic [7:0]    data_q;
    logic          valid_q, perr_q, ferr_q;

    // Stage: two-flop synchronisers, then clock filter (idle level of the bus is 1)
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            clk_sync_p0 <= 1'b1;
            clk_sync_p1 <= 1'b1;
            dat_sync_p0 <= 1'b1;
            dat_sync_p1 <= 1'b1;
            fclk        <= 1'b1;
            fclk_prev   <= 1'b1;
            fcnt        <= '0;
        end else begin
            clk_sync_p0 <= bus.i_ps2_clk;
            clk_sync_p1 <= clk_sync_p0;
            dat_sync_p0 <= bus.i_ps2_dat;
            dat_sync_p1 <= dat_sync_p0;
            fclk_prev   <= fclk;
            if (clk_sync_p1 != fclk) begin
                if (fcnt == 4'(FILTER_LEN - 1)) begin
                    fclk <= clk_sync_p1;
                    fcnt <= '0;
                end else begin
                    fcnt <= fcnt + 4'd1;
                end
            end else begin
                fcnt <= '0;
            end
        end
    end

    assign fall    = fclk_prev & ~fclk;
    assign sample  = dat_sync_p1;
    assign timeout = (state != IDLE) && (tcnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    // Timeout beats a coincident edge: the edge is simply dropped.
    always_comb begin
        state_nxt = state;
        if (timeout) begin
            state_nxt = IDLE;
        end else if (fall) begin
            case (state)
                IDLE:    if (!sample) state_nxt = DATA;
                DATA:    if (bitcnt == 3'd7) state_nxt = PARITY;
                PARITY:  state_nxt = STOP;
                STOP:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        shift_en  = 1'b0;
        par_en    = 1'b0;
        valid_nxt = 1'b0;
        perr_nxt  = 1'b0;
        ferr_nxt  = timeout;
        if (fall && !timeout) begin
            case (state)
                DATA:    shift_en = 1'b1;
                PARITY:  par_en   = 1'b1;
                STOP: begin
                    valid_nxt = sample && (^{shreg, par_bit});
                    perr_nxt  = sample && !(^{shreg, par_bit});
                    ferr_nxt  = !sample;
                end
                default: ;
            endcase
        end
    end

    // Stage: frame counters and registered strobes
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            bitcnt  <= '0;
            tcnt    <= '0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            if (state == IDLE || timeout)
                bitcnt <= '0;
            else if (shift_en)
                bitcnt <= bitcnt + 3'd1;
            if (state == IDLE || fall || timeout)
                tcnt <= '0;
            else
                tcnt <= tcnt + TW'(1);
            if (valid_nxt)
                data_q <= shreg;
            valid_q <= valid_nxt;
            perr_q  <= perr_nxt;
            ferr_q  <= ferr_nxt;
        end
    end

    // LSB arrives first, so bits enter at the top and walk down.
    always_ff @(posedge i_clk) begin
        if (shift_en) shreg   <= {sample, shreg[7:1]};
        if (par_en)   par_bit <= sample;
    end

    assign bus.o_data       = data_q;
    assign bus.o_valid      = valid_q;
    assign bus.o_parity_err = perr_q;
    assign bus.o_frame_err  = ferr_q;
    assign bus.o_busy       = (state != IDLE);
endmodule

// File: tb/tb_ps2_rx_frame.sv
// Scoreboard bench for ps2_rx_frame: stimulus pushes expected strobes, a negedge monitor checks them.
module tb_ps2_rx_frame;
    localparam int FL  = 4;
    localparam int TO  = 600;
    localparam int HP  = 25;
    localparam int LAT = FL + 3;

    typedef struct {
        int         kind;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   last_fall = 0;
    logic chk_reset = 1'b1;
    logic chk_quiet = 1'b0;
    logic drain_expired = 1'b0;
    logic final_chk = 1'b0;
    logic [7:0] model_data = 8'h00;
    exp_t sb[$];

    ps2_rx_frame_if bus();

    ps2_rx_frame #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int expv);
        tests++;
        if (got != expv) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, expv, cyc);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        int   ns;
        int   kind_got;
        if (chk_reset) begin
            check("rst_data",  int'(bus.o_data), 0);
            check("rst_valid", int'(bus.o_valid), 0);
            check("rst_perr",  int'(bus.o_parity_err), 0);
            check("rst_ferr",  int'(bus.o_frame_err), 0);
            check("rst_busy",  int'(bus.o_busy), 0);
        end
        if (chk_quiet) check("glitch_busy", int'(bus.o_busy), 0);
        if (drain_expired) begin
            check("strobe_missing", sb.size(), 0);
            sb.delete();
        end
        if (final_chk) check("sb_empty", sb.size(), 0);
        if (!rst) begin
            ns = int'(bus.o_valid) + int'(bus.o_parity_err) + int'(bus.o_frame_err);
            kind_got = bus.o_valid ? 0 : (bus.o_parity_err ? 1 : 2);
            if (ns > 1) begin
                check("strobe_excl", ns, 1);
            end else if (ns == 1) begin
                if (sb.size() == 0) begin
                    check("unexpected_strobe_kind", kind_got, -1);
                end else begin
                    e = sb.pop_front();
                    check("strobe_kind", kind_got, e.kind);
                    check("data", int'(bus.o_data), int'(e.data));
                    check("latency_cycle", cyc, e.cyc);
                    check("busy_at_strobe", int'(bus.o_busy), 0);
                end
            end
        end
    end

    task automatic bit_fall(input logic b);
        @(posedge clk); #1 bus.i_ps2_dat = b;
        repeat (HP) @(posedge clk);
        #1 bus.i_ps2_clk = 1'b0;
        last_fall = cyc;
    endtask

    task automatic bit_rise();
        repeat (HP) @(posedge clk);
        #1 bus.i_ps2_clk = 1'b1;
    endtask

    task automatic send_bit(input logic b);
        bit_fall(b);
        bit_rise();
    endtask

    task automatic push_exp(input int kind, input logic [7:0] d, input int at);
        exp_t e;
        e.kind = kind;
        e.cyc  = at;
        if (kind == 0) model_data = d;
        e.data = model_data;
        sb.push_back(e);
    endtask

    // kind: 0 = valid, 1 = parity error, 2 = frame error
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp, input int kind);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par);
        bit_fall(stp);
        push_exp(kind, d, last_fall + LAT);
        bit_rise();
    endtask

    task automatic drain(input int maxc);
        for (int i = 0; i < maxc && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            #1 drain_expired = 1'b1;
            @(posedge clk); #1 drain_expired = 1'b0;
        end
        repeat (10) @(posedge clk);
    endtask

    initial begin
        bus.i_ps2_clk = 1'b1;
        bus.i_ps2_dat = 1'b1;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0; chk_reset = 1'b0;
        repeat (10) @(posedge clk);

        send_frame(8'h1C, 1'b0, 1'b1, 0);
        drain(200);
        send_frame(8'h1C, 1'b1, 1'b1, 1);
        drain(200);
        send_frame(8'hF0, 1'b1, 1'b0, 2);
        drain(200);
        send_frame(8'hF0, 1'b1, 1'b1, 0);
        drain(200);

        // Stalled frame: start plus four data bits, clock then held high
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        bit_fall(1'b1);
        push_exp(2, 8'h00, last_fall + LAT + TO);
        bit_rise();
        drain(TO + 300);
        send_frame(8'h1C, 1'b0, 1'b1, 0);
        drain(200);

        // Short low pulse on the clock while idle with data low
        @(posedge clk); #1 bus.i_ps2_dat = 1'b0; chk_quiet = 1'b1;
        @(posedge clk); #1 bus.i_ps2_clk = 1'b0;
        @(posedge clk); @(posedge clk); #1 bus.i_ps2_clk = 1'b1;
        repeat (20) @(posedge clk);
        #1 chk_quiet = 1'b0; bus.i_ps2_dat = 1'b1;
        repeat (5) @(posedge clk);

        // Reset in the middle of a frame
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(i[0]);
        @(posedge clk); #1 rst = 1'b1; chk_reset = 1'b1; model_data = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0; chk_reset = 1'b0;
        repeat (10) @(posedge clk);
        send_frame(8'h5A, 1'b1, 1'b1, 0);
        drain(200);

        repeat (20) @(posedge clk);
        #1 final_chk = 1'b1;
        @(posedge clk); #1 final_chk = 1'b0;
        @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
